rr_operand_arbiter: RTL and testbench
=====================================

Name: rr_operand_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4-input, 4-bit datapath.
- Four requesters each present an operand and a request line.
- The block grants one requester at a time and drives the 2-bit operand select plus the 2-bit phase control (11 = load, 10 = hold) that the datapath consumes.
- It captures the granted operand into a registered output and returns a one-cycle acknowledge when the grant window closes.

Parameters:
W, 4, operand and output width in bits
HOLD, 2, grant window length in cycles (legal values >= 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request per requester; bit i belongs to requester i
in0  input  W  operand of requester 0
in1  input  W  operand of requester 1
in2  input  W  operand of requester 2
in3  input  W  operand of requester 3
gnt  output 4  one-hot grant, 0000 when idle
sel  output 2  index of the granted requester (operand select to datapath)
phase output 2  00 idle, 11 load (first grant cycle), 10 hold (remaining cycles)
out  output W  captured operand of the current or last grant
valid output 1  one-cycle pulse: out updated on this edge
ack  output 4  one-cycle one-hot pulse at grant release

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled only at the clk rising edge.
- Reset values: gnt=0000, sel=00, phase=00, out=0, valid=0, ack=0000, state=IDLE, cnt=0, priority pointer ptr=0.
- All outputs are registered. No combinational path from input to output.
- Arbitration:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - ptr updates to (winner+1) mod 4 at grant release.
- FSM states:
  - IDLE → BUSY when req!=0. At that edge: gnt<=onehot(w), sel<=w, phase<=11, cnt<=HOLD-1.
  - IDLE with req==0: all outputs hold. sel keeps its last value.
  - BUSY, phase=11 edge: out<=in[sel], valid<=1. All other edges: valid<=0.
  - BUSY, cnt!=0: cnt<=cnt-1, phase<=10.
  - BUSY, cnt==0 (release edge): ack<=onehot(sel), ptr<=sel+1 mod 4. Then re-arbitrate on req with bit sel masked, using the new ptr.
    - If there is a winner: new grant is loaded on the same edge (phase<=11, no idle cycle).
    - Otherwise: gnt<=0000, phase<=00, state<=IDLE.
- Latency, for req seen at edge k:
  - gnt/sel/phase=11 after edge k.
  - out/valid after edge k+1.
  - ack after edge k+HOLD.
  - Each grant occupies exactly HOLD cycles.
- HOLD=1: the capture edge is also the release edge. valid and ack pulse together; phase never shows 10.
- Operand is captured once per grant. Input changes during 10 cycles do not affect out.
- Req dropped mid-grant: the grant runs to completion and ack is still issued. No abort path except rst.
- Req of a non-granted requester changing mid-grant: no effect until the release edge.
- rst during BUSY: abort on that edge. No ack is emitted; all registers return to reset values, including ptr=0.
- rst and req both high: rst wins. The first grant is decided at the first edge with rst=0.
- gnt is always one-hot or zero. ack is never asserted for more than one cycle or more than one bit.

Test Plan:
1. Reset: rst=1 for 2 edges with req=1111, in*=15 → gnt=0000, sel=0, phase=00, out=0, valid=0, ack=0000 throughout.
2. Single request, HOLD=2: req=0100, in2=9 at edge k.
   - After k: gnt=0100, sel=2, phase=11.
   - After k+1: out=9, valid=1, phase=10.
   - After k+2: ack=0100, gnt=0000, phase=00.
3. Rotation: req=1111 held, in0..in3=1,2,3,4 → grants 0,1,2,3,0 back-to-back. out sequence 1,2,3,4,1. One ack per grant; phase pattern 11,10 repeating with no 00.
4. Fairness after release: req=0011, first grant goes to requester 0. req stays 0011 → next grant goes to 1 (not 0). Then back to 0.
5. Mid-grant events, HOLD=3: req=0010, in1=5.
   - After capture: in1=12 and req=0000.
   - Required: out stays 5, ack=0010 at k+3, then IDLE.
6. Reset mid-grant: rst=1 during phase=10 of a requester-3 grant → next edge all outputs zero and no ack. With req=1001 after reset, requester 0 is granted first (ptr=0).

Source files
------------

// File: rtl/rr_operand_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-input datapath: grants one
// requester for HOLD cycles, drives operand select/phase, captures the operand, acks on release.
module rr_operand_arbiter #(
  parameter int W    = 4,
  parameter int HOLD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [1:0]   phase,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [3:0]   ack
);

  typedef enum logic { IDLE, BUSY } state_t;

  localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
  localparam logic [1:0]    PH_IDLE  = 2'b00;
  localparam logic [1:0]    PH_LOAD  = 2'b11;
  localparam logic [1:0]    PH_HOLD  = 2'b10;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    ptr;
  logic [W-1:0]  operand;
  logic [2:0]    idle_pick;
  logic [2:0]    rel_pick;

  // Returns {found, index} of the first set bit of r scanning p, p+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    operand = in0;
    case (sel)
      2'd1:    operand = in1;
      2'd2:    operand = in2;
      2'd3:    operand = in3;
      default: operand = in0;
    endcase
  end

  // At release the current holder is masked and the scan starts just past it.
  assign idle_pick = pick(req, ptr);
  assign rel_pick  = pick(req & ~onehot(sel), sel + 2'd1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= '0;
      phase <= PH_IDLE;
      out   <= '0;
      valid <= 1'b0;
      ack   <= '0;
    end else begin
      valid <= 1'b0;
      ack   <= '0;
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state <= BUSY;
            gnt   <= onehot(idle_pick[1:0]);
            sel   <= idle_pick[1:0];
            phase <= PH_LOAD;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (phase == PH_LOAD) begin
            out   <= operand;
            valid <= 1'b1;
          end
          if (cnt != '0) begin
            cnt   <= cnt - CW'(1);
            phase <= PH_HOLD;
          end else begin
            ack <= onehot(sel);
            ptr <= sel + 2'd1;
            if (rel_pick[2]) begin
              gnt   <= onehot(rel_pick[1:0]);
              sel   <= rel_pick[1:0];
              phase <= PH_LOAD;
              cnt   <= CNT_INIT;
            end else begin
              gnt   <= '0;
              phase <= PH_IDLE;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_operand_arbiter.sv
// Self-checking bench for rr_operand_arbiter: table-driven vectors on a HOLD=2
// instance plus hand sequences for HOLD=3 mid-grant events, HOLD=1 and reset mid-grant.
module tb_rr_operand_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] in0, in1, in2, in3;

  logic [3:0] g2, g3, g1, a2, a3, a1;
  logic [1:0] s2, s3, s1, p2, p3, p1;
  logic [3:0] o2, o3, o1;
  logic       v2, v3, v1;

  int n_checks = 0;
  int n_pass   = 0;

  rr_operand_arbiter #(.W(4), .HOLD(2)) d2 (
    .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(g2), .sel(s2), .phase(p2), .out(o2), .valid(v2), .ack(a2)
  );
  rr_operand_arbiter #(.W(4), .HOLD(3)) d3 (
    .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(g3), .sel(s3), .phase(p3), .out(o3), .valid(v3), .ack(a3)
  );
  rr_operand_arbiter #(.W(4), .HOLD(1)) d1 (
    .clk(clk), .rst(rst), .req(req), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(g1), .sel(s1), .phase(p1), .out(o1), .valid(v1), .ack(a1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] g;
    logic [1:0] s;
    logic [1:0] p;
    logic [3:0] o;
    logic       v;
    logic [3:0] a;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] i0, logic [3:0] i1,
                              logic [3:0] i2, logic [3:0] i3, logic [3:0] g, logic [1:0] s,
                              logic [1:0] p, logic [3:0] o, logic v, logic [3:0] a);
    vec_t t;
    t.rst = r; t.req = rq; t.i0 = i0; t.i1 = i1; t.i2 = i2; t.i3 = i3;
    t.g = g; t.s = s; t.p = p; t.o = o; t.v = v; t.a = a;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag,
                           input logic [3:0] g, input logic [1:0] s, input logic [1:0] p,
                           input logic [3:0] o, input logic v, input logic [3:0] a,
                           input logic [3:0] eg, input logic [1:0] es, input logic [1:0] ep,
                           input logic [3:0] eo, input logic ev, input logic [3:0] ea);
    check({tag, ".gnt"},   32'(g), 32'(eg));
    check({tag, ".sel"},   32'(s), 32'(es));
    check({tag, ".phase"}, 32'(p), 32'(ep));
    check({tag, ".out"},   32'(o), 32'(eo));
    check({tag, ".valid"}, 32'(v), 32'(ev));
    check({tag, ".ack"},   32'(a), 32'(ea));
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] i0,
                       input logic [3:0] i1, input logic [3:0] i2, input logic [3:0] i3);
    rst = r; req = rq; in0 = i0; in1 = i1; in2 = i2; in3 = i3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);

    // Reset with all requests high, then single request, then idle hold.
    vecs.push_back(mk(1, 4'b1111, 15, 15, 15, 15, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 4'b1111, 15, 15, 15, 15, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 9, 0, 4'b0100, 2, 2'b11, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 9, 0, 4'b0100, 2, 2'b10, 9, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 9, 0, 4'b0000, 2, 2'b00, 9, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 9, 0, 4'b0000, 2, 2'b00, 9, 0, 4'b0000));
    // Full rotation 0,1,2,3,0 with back-to-back grants.
    vecs.push_back(mk(1, 4'b1111, 1, 2, 3, 4, 4'b0000, 0, 2'b00, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0001, 0, 2'b11, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0001, 0, 2'b10, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0010, 1, 2'b11, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0010, 1, 2'b10, 2, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0100, 2, 2'b11, 2, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0100, 2, 2'b10, 3, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b1000, 3, 2'b11, 3, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b1000, 3, 2'b10, 4, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 1, 2, 3, 4, 4'b0001, 0, 2'b11, 4, 0, 4'b1000));
    // Fairness with req=0011: alternate 0,1,0 after each release.
    vecs.push_back(mk(0, 4'b0011, 1, 2, 3, 4, 4'b0001, 0, 2'b10, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b0011, 1, 2, 3, 4, 4'b0010, 1, 2'b11, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0011, 1, 2, 3, 4, 4'b0010, 1, 2'b10, 2, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b0011, 1, 2, 3, 4, 4'b0001, 0, 2'b11, 2, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0011, 1, 2, 3, 4, 4'b0001, 0, 2'b10, 1, 1, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, 1, 2, 3, 4, 4'b0000, 0, 2'b00, 1, 0, 4'b0001));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].i3);
      step();
      check_all($sformatf("row%0d", i), g2, s2, p2, o2, v2, a2,
                vecs[i].g, vecs[i].s, vecs[i].p, vecs[i].o, vecs[i].v, vecs[i].a);
    end

    // HOLD=3 mid-grant input/req changes; HOLD=1 runs alongside on the same stimulus.
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    step();
    check_all("h3_rst", g3, s3, p3, o3, v3, a3, 4'b0000, 0, 2'b00, 0, 0, 4'b0000);
    drive(1'b0, 4'b0010, 0, 5, 0, 0);
    step();
    check_all("h3_k",  g3, s3, p3, o3, v3, a3, 4'b0010, 1, 2'b11, 0, 0, 4'b0000);
    check_all("h1_k",  g1, s1, p1, o1, v1, a1, 4'b0010, 1, 2'b11, 0, 0, 4'b0000);
    step();
    check_all("h3_k1", g3, s3, p3, o3, v3, a3, 4'b0010, 1, 2'b10, 5, 1, 4'b0000);
    check_all("h1_k1", g1, s1, p1, o1, v1, a1, 4'b0000, 1, 2'b00, 5, 1, 4'b0010);
    drive(1'b0, 4'b0000, 0, 12, 0, 0);
    step();
    check_all("h3_k2", g3, s3, p3, o3, v3, a3, 4'b0010, 1, 2'b10, 5, 0, 4'b0000);
    check_all("h1_k2", g1, s1, p1, o1, v1, a1, 4'b0000, 1, 2'b00, 5, 0, 4'b0000);
    step();
    check_all("h3_k3", g3, s3, p3, o3, v3, a3, 4'b0000, 1, 2'b00, 5, 0, 4'b0010);
    step();
    check_all("h3_k4", g3, s3, p3, o3, v3, a3, 4'b0000, 1, 2'b00, 5, 0, 4'b0000);

    // Reset during the hold phase of a requester-3 grant; ptr returns to 0.
    drive(1'b1, 4'b0000, 0, 0, 0, 0);
    step();
    drive(1'b0, 4'b1000, 6, 0, 0, 7);
    step();
    check_all("rm_g",   g2, s2, p2, o2, v2, a2, 4'b1000, 3, 2'b11, 0, 0, 4'b0000);
    step();
    check_all("rm_cap", g2, s2, p2, o2, v2, a2, 4'b1000, 3, 2'b10, 7, 1, 4'b0000);
    drive(1'b1, 4'b1001, 6, 0, 0, 7);
    step();
    check_all("rm_rst", g2, s2, p2, o2, v2, a2, 4'b0000, 0, 2'b00, 0, 0, 4'b0000);
    drive(1'b0, 4'b1001, 6, 0, 0, 7);
    step();
    check_all("rm_g0",  g2, s2, p2, o2, v2, a2, 4'b0001, 0, 2'b11, 0, 0, 4'b0000);
    step();
    check_all("rm_c0",  g2, s2, p2, o2, v2, a2, 4'b0001, 0, 2'b10, 6, 1, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
